// File: rtl/comb_sweep_pkg.sv
// Shared types and constants for the combinational-circuit sweep sequencer.
// Holds the FSM state encoding, default MISR setup and the MISR step function.
package comb_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_e;

    localparam int          SIG_W_DEF = 16;
    localparam logic [15:0] POLY_DEF  = 16'h1021;
    localparam logic [15:0] SEED_DEF  = 16'hFFFF;

    // One MISR clock at the default signature width: shift, fold the MSB through poly, xor data.
    function automatic logic [SIG_W_DEF-1:0] misr_step(
        input logic [SIG_W_DEF-1:0] sig,
        input logic [SIG_W_DEF-1:0] data,
        input logic [SIG_W_DEF-1:0] poly = POLY_DEF
    );
        return {sig[SIG_W_DEF-2:0], 1'b0} ^ (sig[SIG_W_DEF-1] ? poly : '0) ^ data;
    endfunction

endpackage

// File: rtl/comb_sweep_misr.sv
// Signature register for the sweep: loads SEED on request, folds one sample per step.
// Load wins over step; reset also returns the register to SEED.
module comb_sweep_misr
    import comb_sweep_pkg::*;
#(
    parameter int               SIG_W = SIG_W_DEF,
    parameter int               N_OUT = 3,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [N_OUT-1:0] data_i,
    output logic [SIG_W-1:0] sig_o
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic [SIG_W-1:0] data_ext;
    logic [SIG_W-1:0] step_val;

    assign data_ext = SIG_W'(data_i);

    if (SIG_W == SIG_W_DEF) begin : g_pkg_step
        assign step_val = misr_step(sig_q, data_ext, POLY);
    end else begin : g_gen_step
        assign step_val = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ data_ext;
    end

    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = SEED;
        end else if (step_i) begin
            sig_d = step_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/comb_sweep_ctrl.sv
// Sweeps every input vector of a combinational circuit, captures its truth table and a MISR signature.
// Optional expected-table checker is built when COMB_SWEEP_CHECK_EN is defined.
//
//   state  | meaning
//   IDLE   | waiting for start; results from the last sweep held
//   DRIVE  | dut_x applied, counting down the settle window
//   SAMPLE | capture dut_f into the table and MISR, then advance or finish
//   DONE   | one-cycle done pulse, busy already low
module comb_sweep_ctrl
    import comb_sweep_pkg::*;
#(
    parameter int               N_IN   = 3,
    parameter int               N_OUT  = 3,
    parameter int               SETTLE = 1,
    parameter int               SIG_W  = SIG_W_DEF,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(POLY_DEF),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(SEED_DEF)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [N_IN-1:0]               dut_x,
    input  logic [N_OUT-1:0]              dut_f,
    output logic [N_IN-1:0]               vec_idx,
    output logic [N_OUT*(2**N_IN)-1:0]    truth,
    output logic [SIG_W-1:0]              signature
`ifdef COMB_SWEEP_CHECK_EN
    ,
    input  logic [N_OUT*(2**N_IN)-1:0]    exp_truth,
    output logic [N_IN:0]                 mismatches,
    output logic [N_IN-1:0]               first_fail,
    output logic                          pass
`endif
);

    localparam int              TW       = N_OUT * (2**N_IN);
    localparam logic [N_IN-1:0] LAST_IDX = '1;
    localparam logic [3:0]      SETTLE_W = 4'(SETTLE);

    state_e            state_q;
    logic [N_IN-1:0]   idx_q;
    logic [N_IN-1:0]   idx_d;
    logic [3:0]        settle_q;
    logic              busy_q;
    logic              done_q;
    logic [TW-1:0]     truth_q;
    logic              accept;
    logic              sample;
    int                slot;

    assign accept = (state_q == IDLE) && start;
    assign sample = (state_q == SAMPLE);
    assign idx_d  = idx_q + 1'b1;
    assign slot   = int'(idx_q) * N_OUT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            truth_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= DRIVE;
                        idx_q    <= '0;
                        settle_q <= SETTLE_W;
                        truth_q  <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (settle_q != 4'd0) begin
                        settle_q <= settle_q - 4'd1;
                    end else begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    truth_q[slot +: N_OUT] <= dut_f;
                    // Last vector ends the sweep; idx is left at the top so it never wraps.
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q    <= idx_d;
                        settle_q <= SETTLE_W;
                        state_q  <= DRIVE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    comb_sweep_misr #(
        .SIG_W (SIG_W),
        .N_OUT (N_OUT),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .step_i (sample),
        .data_i (dut_f),
        .sig_o  (signature)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign dut_x   = idx_q;
    assign vec_idx = idx_q;
    assign truth   = truth_q;

`ifdef COMB_SWEEP_CHECK_EN
    logic [N_IN:0]   mism_q;
    logic [N_IN-1:0] first_q;
    logic            miss;

    assign miss = sample && (dut_f != exp_truth[slot +: N_OUT]);

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            mism_q  <= '0;
            first_q <= '0;
        end else if (miss) begin
            // Vectors arrive in ascending order, so the first miss is the lowest failing index.
            if (mism_q == '0) begin
                first_q <= idx_q;
            end
            mism_q <= mism_q + 1'b1;
        end
    end

    assign mismatches = mism_q;
    assign first_fail = first_q;
    assign pass       = (mism_q == '0);
`endif

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Bench for comb_sweep_ctrl: three instances (SETTLE 1, 0, 3) driving a random LUT circuit,
// compared against a table/arithmetic reference model; checker ports exercised when COMB_SWEEP_CHECK_EN is set.
module tb_comb_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a [3];
    logic        busy_a  [3];
    logic        done_a  [3];
    logic [2:0]  x_a     [3];
    logic [2:0]  idx_a   [3];
    logic [2:0]  f_a     [3];
    logic [23:0] truth_a [3];
    logic [15:0] sig_a   [3];
    logic [2:0]  lut     [8];
`ifdef COMB_SWEEP_CHECK_EN
    logic [23:0] exp_tbl;
    logic [3:0]  mism_a  [3];
    logic [2:0]  ff_a    [3];
    logic        pass_a  [3];
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int S = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        assign f_a[g] = lut[x_a[g]];
        comb_sweep_ctrl #(.N_IN(3), .N_OUT(3), .SETTLE(S)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_a[g]),
            .busy      (busy_a[g]),
            .done      (done_a[g]),
            .dut_x     (x_a[g]),
            .dut_f     (f_a[g]),
            .vec_idx   (idx_a[g]),
            .truth     (truth_a[g]),
            .signature (sig_a[g])
`ifdef COMB_SWEEP_CHECK_EN
            ,
            .exp_truth  (exp_tbl),
            .mismatches (mism_a[g]),
            .first_fail (ff_a[g]),
            .pass       (pass_a[g])
`endif
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int settle_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    function automatic logic [23:0] ref_truth();
        logic [23:0] t = '0;
        for (int v = 0; v < 8; v++) t[v*3 +: 3] = lut[v];
        return t;
    endfunction

    // Signature as polynomial arithmetic: multiply by x modulo the feedback, then add the sample.
    function automatic logic [15:0] ref_sig();
        int unsigned s = 32'hFFFF;
        for (int v = 0; v < 8; v++) begin
            s = s * 2;
            if (s >= 32'h10000) s = (s - 32'h10000) ^ 32'h1021;
            s = s ^ {29'd0, lut[v]};
        end
        return s[15:0];
    endfunction

    task automatic rand_lut();
        for (int v = 0; v < 8; v++) lut[v] = 3'($urandom_range(0, 7));
    endtask

`ifdef COMB_SWEEP_CHECK_EN
    task automatic chk_checker(input int k);
        int m = 0;
        int ff = 0;
        for (int v = 7; v >= 0; v--) begin
            if (lut[v] != exp_tbl[v*3 +: 3]) begin
                m++;
                ff = v;
            end
        end
        chk("mismatches", 32'(mism_a[k]), m);
        chk("first_fail", 32'(ff_a[k]), ff);
        chk("pass", 32'(pass_a[k]), (m == 0) ? 1 : 0);
    endtask
`endif

    // One sweep on instance k; optionally pokes start at cycle poke_c or asserts reset at cycle rst_c.
    task automatic sweep(input int k, input int poke_c, input int rst_c);
        int s = settle_of(k);
        int total = 8 * (s + 2) + 1;
        int done_n = 0;
        int done_c = 0;
        int busy_n = 0;
        int xbad = 0;
        logic [2:0]  ev;
        logic [23:0] et = ref_truth();
        logic [15:0] es = ref_sig();
        start_a[k] = 1'b1;
        @(posedge clk); #1;
        start_a[k] = 1'b0;
        for (int c = 1; c <= total + 3; c++) begin
            if (c < total) begin
                ev = 3'((c - 1) / (s + 2));
                if (x_a[k] !== ev || idx_a[k] !== ev) xbad++;
            end
            if (busy_a[k]) busy_n++;
            if (done_a[k]) begin
                done_n++;
                done_c = c;
            end
            if (c == poke_c) start_a[k] = 1'b1;
            if (c == rst_c) rst = 1'b1;
            @(posedge clk); #1;
            start_a[k] = 1'b0;
            if (c == rst_c) begin
                rst = 1'b0;
                chk("rst_busy", 32'(busy_a[k]), 0);
                chk("rst_x", 32'(x_a[k]), 0);
                chk("rst_truth", 32'(truth_a[k]), 0);
                chk("rst_sig", 32'(sig_a[k]), 32'hFFFF);
                chk("rst_x_before", xbad, 0);
                repeat (total) begin
                    @(posedge clk); #1;
                    if (done_a[k]) done_n++;
                end
                chk("rst_no_done", done_n, 0);
                return;
            end
        end
        chk("x_hold", xbad, 0);
        chk("done_count", done_n, 1);
        chk("done_cycle", done_c, total);
        chk("busy_cycles", busy_n, total - 1);
        chk("truth", 32'(truth_a[k]), 32'(et));
        chk("signature", 32'(sig_a[k]), 32'(es));
`ifdef COMB_SWEEP_CHECK_EN
        chk_checker(k);
`endif
    endtask

    initial begin
        int found;
        int dc;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) start_a[k] = 1'b0;
        for (int v = 0; v < 8; v++) lut[v] = 3'(v);
`ifdef COMB_SWEEP_CHECK_EN
        exp_tbl = 24'hFAC688;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy_a[0]), 0);
        chk("reset_done", 32'(done_a[0]), 0);
        chk("reset_x", 32'(x_a[0]), 0);
        chk("reset_truth", 32'(truth_a[0]), 0);
        chk("reset_sig", 32'(sig_a[0]), 32'hFFFF);
        rst = 1'b0;
        @(posedge clk); #1;

        sweep(0, 0, 0);
        chk("identity_table", 32'(truth_a[0]), 32'h00FAC688);

        rand_lut();
        sweep(0, 5, 0);

        rand_lut();
        sweep(0, 0, 10);

        rand_lut();
        sweep(1, 0, 0);
        rand_lut();
        sweep(2, 0, 0);

        // start held high: sweep restarts on the first IDLE cycle after DONE
        rand_lut();
        start_a[0] = 1'b1;
        @(posedge clk); #1;
        found = 0;
        dc = 0;
        for (int c = 1; c <= 200 && found == 0; c++) begin
            if (done_a[0]) begin
                found = 1;
                dc = c;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("held_done_cycle", dc, 25);
        @(posedge clk); #1;
        chk("held_idle_busy", 32'(busy_a[0]), 0);
        @(posedge clk); #1;
        chk("held_restart_busy", 32'(busy_a[0]), 1);
        start_a[0] = 1'b0;
        found = 0;
        for (int c = 0; c <= 200 && found == 0; c++) begin
            if (done_a[0]) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("held_second_done", found, 1);
        chk("held_truth", 32'(truth_a[0]), 32'(ref_truth()));
        chk("held_sig", 32'(sig_a[0]), 32'(ref_sig()));
        repeat (3) @(posedge clk);
        #1;
        chk("held_stays_idle", 32'(busy_a[0]), 0);

        for (int r = 0; r < 4; r++) begin
            rand_lut();
`ifdef COMB_SWEEP_CHECK_EN
            exp_tbl = 24'($urandom);
`endif
            sweep(r % 3, 0, 0);
        end

`ifdef COMB_SWEEP_CHECK_EN
        exp_tbl = 24'hFAC688;
        for (int v = 0; v < 8; v++) lut[v] = ~3'(v);
        sweep(0, 0, 0);
        chk("inv_mism_lit", 32'(mism_a[0]), 8);
        chk("inv_pass_lit", 32'(pass_a[0]), 0);
        for (int v = 0; v < 8; v++) lut[v] = 3'd0;
        sweep(0, 0, 0);
        chk("zero_mism_lit", 32'(mism_a[0]), 7);
        chk("zero_first_lit", 32'(ff_a[0]), 1);
        for (int v = 0; v < 8; v++) lut[v] = 3'(v);
        sweep(0, 0, 0);
        chk("ident_mism_lit", 32'(mism_a[0]), 0);
        chk("ident_pass_lit", 32'(pass_a[0]), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
